// File: rtl/fwd_scoreboard_if.sv
// ID-stage hazard bus between the decode stage and the forwarding scoreboard.
// The decode stage is the master; the scoreboard is the slave.
interface fwd_scoreboard_if #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int SEL_W      = 2
);
    logic                          id_valid;
    logic [NUM_SRC*REG_ADDR_W-1:0] id_src;
    logic [REG_ADDR_W-1:0]         id_rd;
    logic                          id_regwrite;
    logic                          id_memread;
    logic                          id_flush;
    logic                          fwd_en;
    logic                          stall;
    logic [NUM_SRC*SEL_W-1:0]      ex_fwd_sel;
    logic [15:0]                   stall_cnt;

    modport master (
        output id_valid, id_src, id_rd, id_regwrite, id_memread, id_flush, fwd_en,
        input  stall, ex_fwd_sel, stall_cnt
    );

    modport slave (
        input  id_valid, id_src, id_rd, id_regwrite, id_memread, id_flush, fwd_en,
        output stall, ex_fwd_sel, stall_cnt
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks in-flight destination tags, resolves ID-stage
// hazards into registered EX forward selects, load-use stalls and a stall counter.
module fwd_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_DEPTH  = 2,
    parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input logic           clk,
    input logic           rst,
    fwd_scoreboard_if.slave bus
);
    // Load data first becomes forwardable from this select value onward.
    localparam int LOAD_FWD_STAGE = 2;

    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] rd;
        logic                  rw;
        logic                  ld;
    } tag_t;

    tag_t                     tags_q [FWD_DEPTH];
    logic [NUM_SRC*SEL_W-1:0] sel_q;
    logic [15:0]              cnt_q;

    logic                     src_active;
    logic                     issue;
    logic                     stall_c;
    logic                     found;
    logic [REG_ADDR_W-1:0]    src;
    logic [NUM_SRC*SEL_W-1:0] sel_c;

    assign src_active = bus.id_valid & ~bus.id_flush;
    assign issue      = src_active & ~stall_c;

    // NOTE: every variable gets a default at the top of the block, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        stall_c = 1'b0;
        sel_c   = '0;
        found   = 1'b0;
        src     = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src   = bus.id_src[i*REG_ADDR_W +: REG_ADDR_W];
            found = 1'b0;
            // Stage 0 is scanned first, so the youngest producer wins.
            for (int s = 0; s < FWD_DEPTH; s++) begin
                if (src_active && !found && tags_q[s].v && tags_q[s].rw &&
                    (tags_q[s].rd != '0) && (tags_q[s].rd == src)) begin
                    found = 1'b1;
                    if (!bus.fwd_en) begin
                        stall_c = 1'b1;
                    end else if (tags_q[s].ld && (s + 1 < LOAD_FWD_STAGE)) begin
                        stall_c = 1'b1;
                    end else begin
                        sel_c[i*SEL_W +: SEL_W] = SEL_W'(s + 1);
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only the valid bits of the tag pipeline are reset; rd/rw/ld
            // are never looked at while v=0.
            for (int s = 0; s < FWD_DEPTH; s++) begin
                tags_q[s].v <= 1'b0;
            end
            sel_q <= '0;
            cnt_q <= '0;
        end else begin
            tags_q[0] <= '{v: issue, rd: bus.id_rd, rw: bus.id_regwrite, ld: bus.id_memread};
            for (int s = 1; s < FWD_DEPTH; s++) begin
                tags_q[s] <= tags_q[s-1];
            end
            // A bubble or squashed instruction must never forward.
            sel_q <= issue ? sel_c : '0;
            if (stall_c && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign bus.stall      = stall_c;
    assign bus.ex_fwd_sel = sel_q;
    assign bus.stall_cnt  = cnt_q;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed hazard scenarios plus random traffic against
// a history-based reference model, and a counter saturation run on a deep instance.
module tb_fwd_scoreboard;
    localparam int AW = 5;
    localparam int NS = 2;
    localparam int D  = 2;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst;
    logic rst8;
    always #5 clk = ~clk;

    fwd_scoreboard_if #(.REG_ADDR_W(AW), .NUM_SRC(NS), .SEL_W(SW)) bus ();
    fwd_scoreboard_if #(.REG_ADDR_W(AW), .NUM_SRC(NS), .SEL_W(4))  bus8 ();

    fwd_scoreboard #(.REG_ADDR_W(AW), .NUM_SRC(NS), .FWD_DEPTH(D), .SEL_W(SW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    fwd_scoreboard #(.REG_ADDR_W(AW), .NUM_SRC(NS), .FWD_DEPTH(8), .SEL_W(4)) dut8 (
        .clk(clk), .rst(rst8), .bus(bus8)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit           v;
        bit [AW-1:0]  rd;
        bit           rw;
        bit           ld;
    } slot_t;

    // Most recently issued instruction at the front; only the last D are kept.
    slot_t            hist[$];
    logic [NS*SW-1:0] m_sel = '0;
    int               m_cnt = 0;
    logic             obs_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Youngest in-flight writer of each source decides: forward from its age+1,
    // or stall if forwarding is off or load data is not yet available.
    function automatic void model_eval(input bit v, input bit fl, input bit fe,
                                       input int s0, input int s1,
                                       output bit st, output logic [NS*SW-1:0] sel);
        int  srcs[NS];
        bit  hit;
        srcs[0] = s0;
        srcs[1] = s1;
        st  = 1'b0;
        sel = '0;
        if (v && !fl) begin
            for (int i = 0; i < NS; i++) begin
                hit = 1'b0;
                if (srcs[i] != 0) begin
                    for (int age = 0; age < hist.size(); age++) begin
                        if (!hit && hist[age].v && hist[age].rw && int'(hist[age].rd) == srcs[i]) begin
                            hit = 1'b1;
                            if (!fe) st = 1'b1;
                            else if (hist[age].ld && age + 1 < 2) st = 1'b1;
                            else sel[i*SW +: SW] = SW'(age + 1);
                        end
                    end
                end
            end
        end
    endfunction

    task automatic step(input bit v, input int s0, input int s1, input int rd,
                        input bit rw, input bit ld, input bit fl, input bit fe,
                        input bit r, input string tag);
        bit               st;
        logic [NS*SW-1:0] sel;
        slot_t            ns;
        @(negedge clk);
        rst             = r;
        bus.id_valid    = v;
        bus.id_src      = {AW'(s1), AW'(s0)};
        bus.id_rd       = AW'(rd);
        bus.id_regwrite = rw;
        bus.id_memread  = ld;
        bus.id_flush    = fl;
        bus.fwd_en      = fe;
        #1;
        model_eval(v, fl, fe, s0, s1, st, sel);
        obs_stall = bus.stall;
        check({tag, " stall"}, bus.stall, st);
        check({tag, " sel"}, bus.ex_fwd_sel, m_sel);
        check({tag, " cnt"}, bus.stall_cnt, m_cnt);
        @(posedge clk);
        if (r) begin
            hist.delete();
            m_sel = '0;
            m_cnt = 0;
        end else begin
            if (st && m_cnt < 65535) m_cnt++;
            m_sel = (v && !fl && !st) ? sel : '0;
            ns = '{v: v && !fl && !st, rd: AW'(rd), rw: rw, ld: ld};
            hist.push_front(ns);
            if (hist.size() > D) void'(hist.pop_back());
        end
        #1;
    endtask

    task automatic issue(input int s0, input int s1, input int rd, input bit rw,
                         input bit ld, input bit fe, input string tag);
        step(1'b1, s0, s1, rd, rw, ld, 1'b0, fe, 1'b0, tag);
    endtask

    task automatic idle(input string tag);
        step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, tag);
    endtask

    initial begin
        rst = 1'b1;
        rst8 = 1'b1;
        bus.id_valid = 0; bus.id_src = '0; bus.id_rd = '0; bus.id_regwrite = 0;
        bus.id_memread = 0; bus.id_flush = 0; bus.fwd_en = 1;
        bus8.id_valid = 0; bus8.id_src = '0; bus8.id_rd = '0; bus8.id_regwrite = 0;
        bus8.id_memread = 0; bus8.id_flush = 0; bus8.fwd_en = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset stall", bus.stall, 1'b0);
        check("reset sel", bus.ex_fwd_sel, 4'h0);
        check("reset cnt", bus.stall_cnt, 16'h0);

        // Forward from EX/MEM
        issue(0, 0, 3, 1, 0, 1, "exmem prod");
        issue(3, 0, 9, 0, 0, 1, "exmem cons");
        check("exmem stall0", obs_stall, 1'b0);
        check("exmem sel", bus.ex_fwd_sel, 4'b0001);

        // Forward from MEM/WB
        issue(0, 0, 5, 1, 0, 1, "memwb prod");
        issue(1, 2, 6, 1, 0, 1, "memwb indep");
        issue(0, 5, 10, 0, 0, 1, "memwb cons");
        check("memwb stall0", obs_stall, 1'b0);
        check("memwb sel", bus.ex_fwd_sel, 4'b1000);

        // Load-use: one stall cycle with a bubble, then forward from stage 2
        issue(0, 0, 4, 1, 1, 1, "lu load");
        issue(4, 0, 11, 1, 0, 1, "lu cons1");
        check("lu stall1", obs_stall, 1'b1);
        check("lu bubble sel", bus.ex_fwd_sel, 4'b0000);
        issue(4, 0, 11, 1, 0, 1, "lu cons2");
        check("lu stall2", obs_stall, 1'b0);
        check("lu sel", bus.ex_fwd_sel, 4'b0010);
        check("lu cnt", bus.stall_cnt, 16'd1);

        // Youngest producer wins; r0 never matches
        issue(0, 0, 7, 1, 0, 1, "young p1");
        issue(0, 0, 7, 1, 0, 1, "young p0");
        issue(7, 0, 12, 0, 0, 1, "young cons");
        check("young sel", bus.ex_fwd_sel, 4'b0001);
        issue(0, 0, 0, 1, 0, 1, "r0 prod");
        issue(0, 0, 13, 0, 0, 1, "r0 cons");
        check("r0 stall", obs_stall, 1'b0);
        check("r0 sel", bus.ex_fwd_sel, 4'b0000);

        // Interlock mode: two stall cycles, then issue with sel 0
        issue(0, 0, 3, 1, 0, 0, "il prod");
        issue(3, 0, 14, 1, 0, 0, "il c1");
        check("il stall1", obs_stall, 1'b1);
        issue(3, 0, 14, 1, 0, 0, "il c2");
        check("il stall2", obs_stall, 1'b1);
        issue(3, 0, 14, 1, 0, 0, "il c3");
        check("il stall3", obs_stall, 1'b0);
        check("il sel", bus.ex_fwd_sel, 4'b0000);
        check("il cnt", bus.stall_cnt, 16'd3);

        // Flush beats a load-use stall
        issue(0, 0, 4, 1, 1, 1, "fl load");
        step(1'b1, 4, 0, 15, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "fl cons");
        check("fl stall", obs_stall, 1'b0);
        check("fl bubble sel", bus.ex_fwd_sel, 4'b0000);
        issue(15, 0, 16, 0, 0, 1, "fl after");
        check("fl not tracked", obs_stall, 1'b0);

        // Reset while a load sits in stage 0
        issue(0, 0, 4, 1, 1, 1, "rs load");
        step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "rs reset");
        issue(4, 0, 17, 0, 0, 1, "rs cons");
        check("rs stall", obs_stall, 1'b0);
        check("rs sel", bus.ex_fwd_sel, 4'b0000);
        check("rs cnt", bus.stall_cnt, 16'd0);

        // Random traffic against the reference model
        for (int n = 0; n < 2000; n++) begin
            step($urandom_range(0, 9) != 0,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)),
                 $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 63) == 0, "rand");
        end
        idle("rand drain");

        // Saturation: self-dependent instruction in interlock mode on an
        // 8-deep instance stalls 8 of every 9 cycles.
        @(negedge clk);
        bus8.id_valid = 1; bus8.id_src = {AW'(0), AW'(3)}; bus8.id_rd = AW'(3);
        bus8.id_regwrite = 1; bus8.id_memread = 0; bus8.id_flush = 0; bus8.fwd_en = 0;
        @(posedge clk);
        @(negedge clk);
        rst8 = 1'b0;
        #1;
        check("sat first stall", bus8.stall, 1'b0);
        check("sat reset cnt", bus8.stall_cnt, 16'd0);
        repeat (900) @(posedge clk);
        #1;
        check("sat mid cnt", bus8.stall_cnt, 16'd800);
        repeat (72900) @(posedge clk);
        #1;
        check("sat cnt", bus8.stall_cnt, 16'hFFFF);
        repeat (20) @(posedge clk);
        #1;
        check("sat hold", bus8.stall_cnt, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
